// File: rtl/spi_reg_config.sv
// spi_reg_config
//   SPI target that receives 16-bit configuration frames and drives the five
//   PWM peripheral configuration registers. Frames are MSB first:
//   bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
//   A write is committed atomically once nCS rises at the end of the frame.
//
// Ports
//   clk             system clock
//   rst_n           synchronous active-low reset
//   sclk_in         SPI clock pin (asynchronous, oversampled)
//   copi_in         SPI controller-out pin (asynchronous, oversampled)
//   ncs_in          SPI chip select pin, active low (asynchronous)
//   cipo_out        SPI target-out (readback data, or constant 0)
//   en_reg_out_7_0  register 0x00
//   en_reg_out_15_8 register 0x01
//   en_reg_pwm_7_0  register 0x02
//   en_reg_pwm_15_8 register 0x03
//   pwm_duty_cycle  register 0x04
//   wr_pulse        one-clk pulse when a write commits
//   frame_err       one-clk pulse when a frame is discarded
//
// Optional feature
//   SPI_READBACK_EN: when defined, read frames return the addressed register
//   on cipo_out during the data byte. When undefined, cipo_out is tied to 0.

module spi_reg_config #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_in,
  input  logic       copi_in,
  input  logic       ncs_in,
  output logic       cipo_out,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_pulse,
  output logic       frame_err
);

  localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_copiSync;
  logic [SYNC_STAGES-1:0] r_ncsSync;
  logic                   r_sclkPrev;
  logic                   r_ncsPrev;

  logic [15:0] r_shift;
  logic [4:0]  r_bitCnt;
  logic [7:0]  r_regs [5];
  logic        r_wrPulse;
  logic        r_frameErr;

  logic       w_sclk;
  logic       w_copi;
  logic       w_ncs;
  logic       w_sclkRise;
  logic       w_sclkFall;
  logic       w_ncsFall;
  logic       w_ncsRise;
  logic       w_clearFrame;
  logic       w_shiftEn;
  logic       w_commitWrite;
  logic       w_commitErr;
  logic [6:0] w_addr;

  // Synchronizer chains plus one history flop on SCLK and nCS for edge
  // detection. nCS resets high so that reset release never looks like a
  // frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclkSync <= '0;
      r_copiSync <= '0;
      r_ncsSync  <= '1;
      r_sclkPrev <= 1'b0;
      r_ncsPrev  <= 1'b1;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk_in};
      r_copiSync <= {r_copiSync[SYNC_STAGES-2:0], copi_in};
      r_ncsSync  <= {r_ncsSync[SYNC_STAGES-2:0], ncs_in};
      r_sclkPrev <= w_sclk;
      r_ncsPrev  <= w_ncs;
    end
  end

  assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
  assign w_copi     = r_copiSync[SYNC_STAGES-1];
  assign w_ncs      = r_ncsSync[SYNC_STAGES-1];
  assign w_sclkRise = w_sclk & ~r_sclkPrev;
  assign w_sclkFall = ~w_sclk & r_sclkPrev;
  assign w_ncsFall  = ~w_ncs & r_ncsPrev;
  assign w_ncsRise  = w_ncs & ~r_ncsPrev;
  assign w_addr     = r_shift[14:8];

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // FSM next-state logic; a frame start seen during COMMIT is dropped
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_ncsFall) w_nextState = SHIFT;
      SHIFT:   if (w_ncsRise) w_nextState = COMMIT;
      COMMIT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs. An SCLK edge coinciding with the end of frame is not a bit.
  always_comb begin
    w_clearFrame  = 1'b0;
    w_shiftEn     = 1'b0;
    w_commitWrite = 1'b0;
    w_commitErr   = 1'b0;
    case (r_state)
      IDLE:  w_clearFrame = w_ncsFall;
      SHIFT: w_shiftEn    = w_sclkRise & ~w_ncsRise;
      COMMIT: begin
        if (r_bitCnt != 5'd16)
          w_commitErr = 1'b1;
        else if (r_shift[15]) begin
          if (w_addr <= MAX_ADDR_L) w_commitWrite = 1'b1;
          else                      w_commitErr   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Frame shifter; the counter saturates at 17 so overlong frames stay
  // distinguishable from exact 16-bit frames without wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_bitCnt <= '0;
    end else if (w_clearFrame) begin
      r_shift  <= '0;
      r_bitCnt <= '0;
    end else if (w_shiftEn) begin
      if (r_bitCnt < 5'd16) r_shift  <= {r_shift[14:0], w_copi};
      if (r_bitCnt < 5'd17) r_bitCnt <= r_bitCnt + 5'd1;
    end
  end

  // Configuration registers and status pulses, updated only at COMMIT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) r_regs[i] <= 8'h00;
      r_wrPulse  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_wrPulse  <= w_commitWrite;
      r_frameErr <= w_commitErr;
      if (w_commitWrite) begin
        case (w_addr)
          7'd0:    r_regs[0] <= r_shift[7:0];
          7'd1:    r_regs[1] <= r_shift[7:0];
          7'd2:    r_regs[2] <= r_shift[7:0];
          7'd3:    r_regs[3] <= r_shift[7:0];
          7'd4:    r_regs[4] <= r_shift[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = r_regs[0];
  assign en_reg_out_15_8 = r_regs[1];
  assign en_reg_pwm_7_0  = r_regs[2];
  assign en_reg_pwm_15_8 = r_regs[3];
  assign pwm_duty_cycle  = r_regs[4];
  assign wr_pulse        = r_wrPulse;
  assign frame_err       = r_frameErr;

`ifdef SPI_READBACK_EN
  logic [7:0] r_rbShift;
  logic       r_rbActive;
  logic       w_rbLoad;
  logic [6:0] w_rbAddr;
  logic [7:0] w_rbData;

  // After 7 bits the R/W flag sits in r_shift[6] and the upper address bits
  // in r_shift[5:0]; the incoming bit completes the address.
  assign w_rbLoad = w_shiftEn & (r_bitCnt == 5'd7) & ~r_shift[6];
  assign w_rbAddr = {r_shift[5:0], w_copi};

  // Readback source mux; unmapped addresses read as zero
  always_comb begin
    w_rbData = 8'h00;
    if (w_rbAddr <= MAX_ADDR_L) begin
      case (w_rbAddr)
        7'd0:    w_rbData = r_regs[0];
        7'd1:    w_rbData = r_regs[1];
        7'd2:    w_rbData = r_regs[2];
        7'd3:    w_rbData = r_regs[3];
        7'd4:    w_rbData = r_regs[4];
        default: w_rbData = 8'h00;
      endcase
    end
  end

  // The MSB is presented right after the address completes; shifting starts
  // on the falling edge after bit 9 so the host samples each data bit on the
  // following rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rbShift  <= 8'h00;
      r_rbActive <= 1'b0;
    end else if (r_state != SHIFT || w_ncsRise) begin
      r_rbShift  <= 8'h00;
      r_rbActive <= 1'b0;
    end else if (w_rbLoad) begin
      r_rbShift  <= w_rbData;
      r_rbActive <= 1'b1;
    end else if (r_rbActive && w_sclkFall && r_bitCnt >= 5'd9) begin
      r_rbShift  <= {r_rbShift[6:0], 1'b0};
    end
  end

  assign cipo_out = r_rbActive & r_rbShift[7];
`else
  assign cipo_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_config.sv
// tb_spi_reg_config
//   Scoreboard bench for spi_reg_config. The SPI host tasks push the expected
//   commit event (kind, due cycle, register image) into a queue when a frame
//   ends; a monitor pops and compares whenever wr_pulse or frame_err fires.
//   Readback bytes are compared when SPI_READBACK_EN is defined, otherwise
//   cipo_out must stay 0.

module tb_spi_reg_config;

  localparam int SYNC_STAGES = 2;
  localparam int MAX_ADDR    = 4;
  localparam int HALF        = 6;
  localparam int GAP         = 10;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic sclkPin = 1'b0;
  logic copiPin = 1'b0;
  logic ncsPin  = 1'b1;

  logic       cipo_out;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_pulse, frame_err;

  spi_reg_config #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(MAX_ADDR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk_in         (sclkPin),
    .copi_in         (copiPin),
    .ncs_in          (ncsPin),
    .cipo_out        (cipo_out),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_pulse        (wr_pulse),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  typedef struct {
    bit              isWrite;
    int              dueCycle;
    logic [4:0][7:0] regs;
  } entry_t;

  entry_t          expQ[$];
  entry_t          monEntry;
  logic [4:0][7:0] expRegs = '0;
  logic [4:0][7:0] actRegs;
  int              compared   = 0;
  int              mismatched = 0;

  assign actRegs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                    en_reg_out_15_8, en_reg_out_7_0};

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every status pulse must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && (wr_pulse || frame_err)) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedEvent: got wr=%0b err=%0b, required none",
                 wr_pulse, frame_err);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("eventKind", 64'({wr_pulse, frame_err}),
                    monEntry.isWrite ? 64'h2 : 64'h1);
        checkOutput("eventLatency", 64'(cycleCount), 64'(monEntry.dueCycle));
        checkOutput("regsAtEvent", 64'(actRegs), 64'(monEntry.regs));
      end
    end
  end

  // Clocks nbits bits out MSB first with nCS already low; captures cipo_out
  // just before the rising edges of bits 9..16.
  task automatic sendBits(input logic [31:0] bits, input int nbits,
                          output logic [7:0] rdByte);
    rdByte = 8'h00;
    for (int i = nbits - 1; i >= 0; i--) begin
      copiPin = bits[i];
      repeat (HALF) @(negedge clk);
      if ((nbits - 1 - i) >= 8 && (nbits - 1 - i) < 16)
        rdByte = {rdByte[6:0], cipo_out};
      sclkPin = 1'b1;
      repeat (HALF) @(negedge clk);
      sclkPin = 1'b0;
    end
  endtask

  // Full frame: drives the pins, predicts the commit event and checks the
  // byte seen on cipo_out against the hand-computed value.
  task automatic applyStimulus(input string name, input logic [31:0] bits,
                               input int nbits, input logic [7:0] expRb);
    logic [7:0] rdByte;
    logic [6:0] addr;
    entry_t     e;
    @(negedge clk);
    ncsPin = 1'b0;
    repeat (HALF) @(negedge clk);
    sendBits(bits, nbits, rdByte);
    repeat (HALF) @(negedge clk);
    addr = bits[14:8];
    e.dueCycle = cycleCount + SYNC_STAGES + 2;
    if (nbits == 16 && bits[15] && addr <= 7'(MAX_ADDR)) begin
      expRegs[addr[2:0]] = bits[7:0];
      e.isWrite = 1'b1;
      e.regs    = expRegs;
      expQ.push_back(e);
    end else if (nbits != 16 || bits[15]) begin
      e.isWrite = 1'b0;
      e.regs    = expRegs;
      expQ.push_back(e);
    end
    ncsPin  = 1'b1;
    copiPin = 1'b0;
    repeat (GAP) @(negedge clk);
    checkOutput({name, "_cipo"}, 64'(rdByte), 64'(expRb));
  endtask

  initial begin
    logic [7:0] dummy;
    $display("[TB] start, readback=%0b", RB);

    // Reset held low for two clocks
    repeat (2) @(negedge clk);
    checkOutput("resetRegs", 64'(actRegs), 64'h0);
    checkOutput("resetPulses", 64'({wr_pulse, frame_err}), 64'h0);
    checkOutput("resetCipo", 64'(cipo_out), 64'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    applyStimulus("wrOut70", 32'h80F0, 16, 8'h00);
    checkOutput("afterOut70", 64'(actRegs), 64'h00_00_00_00_F0);

    applyStimulus("wrDuty", 32'h8480, 16, 8'h00);
    applyStimulus("wrPwm158", 32'h8301, 16, 8'h00);
    checkOutput("afterPwm", 64'(actRegs), 64'h80_01_00_00_F0);

    applyStimulus("wrBadAddr", 32'h8555, 16, 8'h00);
    applyStimulus("rdAddr0", 32'h0055, 16, RB ? 8'hF0 : 8'h00);
    checkOutput("afterBadRd", 64'(actRegs), 64'h80_01_00_00_F0);

    applyStimulus("short12", 32'h0000_080F, 12, 8'h00);
    applyStimulus("long20", 32'h0008_12FF, 20, 8'h00);
    applyStimulus("wrOut158", 32'h8122, 16, 8'h00);
    checkOutput("afterLenErr", 64'(actRegs), 64'h80_01_00_22_F0);

    // Reset in the middle of a write frame; pins return idle during reset
    @(negedge clk);
    ncsPin = 1'b0;
    repeat (HALF) @(negedge clk);
    sendBits(32'h0000_0082, 8, dummy);
    rst_n   = 1'b0;
    ncsPin  = 1'b1;
    copiPin = 1'b0;
    repeat (4) @(negedge clk);
    expRegs = '0;
    checkOutput("midFrameReset", 64'(actRegs), 64'h0);
    rst_n = 1'b1;
    repeat (GAP) @(negedge clk);

    applyStimulus("rdAfterReset", 32'h0200, 16, 8'h00);
    applyStimulus("wrPwm70", 32'h82AA, 16, 8'h00);
    applyStimulus("rdPwm70", 32'h0200, 16, RB ? 8'hAA : 8'h00);
    applyStimulus("rdUnmapped", 32'h0700, 16, 8'h00);
    checkOutput("finalRegs", 64'(actRegs), 64'h00_00_AA_00_00);

    // Any event still queued never arrived
    repeat (20) @(negedge clk);
    while (expQ.size() != 0) begin
      monEntry = expQ.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL missingEvent: got none, required %s due cycle %0d",
               monEntry.isWrite ? "wr_pulse" : "frame_err", monEntry.dueCycle);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
